// File: rtl/pfa_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder/subtractor.
// Group (generate, propagate) pairs are packed as {G, P}.
package pfa_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of Kogge-Stone levels needed to span width bits: ceil(log2(width)).
    function automatic int prefix_levels(input int width);
        int lv;
        lv = 0;
        while ((1 << lv) < width) lv++;
        return lv;
    endfunction

    // Prefix operator: hi covers the more significant span, lo the span just below it.
    function automatic logic [1:0] gp_combine(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction

endpackage

// File: rtl/pfa_prefix_tree.sv
// Combinational Kogge-Stone carry tree; the carry-in enters as a generate
// at position -1, and the tree is truncated when WIDTH is not a power of two.
module pfa_prefix_tree
    import pfa_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic             c0,
    output logic [WIDTH-1:0] carry,
    output logic             cout
);

    localparam int LEVELS = prefix_levels(WIDTH);

    logic [WIDTH-1:0] gc, pc, gn, pn, gi;

    // NOTE: every variable written here gets a value on every path before use, so no latch is inferred.
    always_comb begin
        gc = g;
        pc = p;
        gn = g;
        pn = p;
        for (int l = 0; l < LEVELS; l++) begin
            gn = gc;
            pn = pc;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    {gn[i], pn[i]} = gp_combine({gc[i], pc[i]},
                                                {gc[i - (1 << l)], pc[i - (1 << l)]});
                end
            end
            gc = gn;
            pc = pn;
        end
        // gc/pc now hold G[i:0]/P[i:0]; folding c0 yields G[i:-1].
        gi = gc | (pc & {WIDTH{c0}});
    end

    assign carry = {gi[WIDTH-2:0], c0};
    assign cout  = gi[WIDTH-1];

endmodule

// File: rtl/pfa_pipe_param.sv
// 3-stage pipelined Kogge-Stone adder/subtractor with valid/ready backpressure:
// operand conditioning + g/p, prefix carries, then sum/overflow output register.
module pfa_pipe_param
    import pfa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  op_e              in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    logic             v1, v2;
    logic             adv1, adv2, adv3;
    logic [WIDTH-1:0] b_eff;
    logic             c0_in;

    logic [WIDTH-1:0] s1_g, s1_p;
    logic             s1_c0, s1_amsb, s1_bmsb;
    logic [TAG_W-1:0] s1_tag;

    logic [WIDTH-1:0] s2_c, s2_p;
    logic             s2_cout, s2_amsb, s2_bmsb;
    logic [TAG_W-1:0] s2_tag;

    logic [WIDTH-1:0] tree_carry, sum3;
    logic             tree_cout, ovf3;

    // A stage loads when it is empty or its content moves on this cycle.
    assign adv3     = !out_valid || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    assign b_eff = (in_op == OP_SUB) ? ~in_b : in_b;
    assign c0_in = (in_op == OP_SUB) ? 1'b1 : in_cin;

    pfa_prefix_tree #(.WIDTH(WIDTH)) u_tree (
        .g     (s1_g),
        .p     (s1_p),
        .c0    (s1_c0),
        .carry (tree_carry),
        .cout  (tree_cout)
    );

    assign sum3 = s2_p ^ s2_c;
    assign ovf3 = (s2_amsb == s2_bmsb) && (sum3[WIDTH-1] != s2_amsb);

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are cleared along with the valids so outputs read zero after reset.
            v1        <= 1'b0;
            s1_g      <= '0;
            s1_p      <= '0;
            s1_c0     <= 1'b0;
            s1_amsb   <= 1'b0;
            s1_bmsb   <= 1'b0;
            s1_tag    <= '0;
            v2        <= 1'b0;
            s2_c      <= '0;
            s2_p      <= '0;
            s2_cout   <= 1'b0;
            s2_amsb   <= 1'b0;
            s2_bmsb   <= 1'b0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_tag   <= '0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_g    <= in_a & b_eff;
                    s1_p    <= in_a ^ b_eff;
                    s1_c0   <= c0_in;
                    s1_amsb <= in_a[WIDTH-1];
                    s1_bmsb <= b_eff[WIDTH-1];
                    s1_tag  <= in_tag;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    s2_c    <= tree_carry;
                    s2_p    <= s1_p;
                    s2_cout <= tree_cout;
                    s2_amsb <= s1_amsb;
                    s2_bmsb <= s1_bmsb;
                    s2_tag  <= s1_tag;
                end
            end
            if (adv3) begin
                out_valid <= v2;
                if (v2) begin
                    out_sum  <= sum3;
                    out_cout <= s2_cout;
                    out_ovf  <= ovf3;
                    out_tag  <= s2_tag;
                end
            end
        end
    end

endmodule
